// File: rtl/return_addr_stack.sv
// Call/return address stack feeding the program counter's load port (jump_en / jump_addr).
// Define RAS_WRAP_EN to make a CALL on a full stack overwrite the oldest entry instead of dropping the push.
module return_addr_stack #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] call_target,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              conflict
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_prev;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] ret_addr;
  logic              store;
  logic              grow;
  logic              pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign top_prev = top - PTR_W'(1);
  assign ret_addr = pc_addr + ADDR_W'(1);

  // CALL wins over RET, so a pop only happens when call is low.
  assign pop = ret && !call && !empty;

`ifdef RAS_WRAP_EN
  // On full, top already points at the oldest entry, so writing there overwrites it.
  assign store = call;
  assign grow  = call && !full;
`else
  assign store = call && !full;
  assign grow  = store;
`endif

  // NOTE: storage has no reset on purpose; validity is tracked by count alone,
  // which lets the array map onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge CLK) begin
    if (store) mem[top] <= ret_addr;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      top       <= '0;
      count     <= '0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      jump_en <= call || pop;

      if (call)     jump_addr <= call_target;
      else if (pop) jump_addr <= mem[top_prev];

      if (store)    top <= top + PTR_W'(1);
      else if (pop) top <= top_prev;

      if (grow)     count <= count + 1'b1;
      else if (pop) count <= count - 1'b1;

      if (call && full)           overflow  <= 1'b1;
      if (ret && !call && empty)  underflow <= 1'b1;
      if (call && ret)            conflict  <= 1'b1;
    end
  end

endmodule
